// File: rtl/liteic_master_node_read_pkg.sv
// Shared types, widths and the slave address map for the liteic read path.
package liteic_pkg;

  localparam int unsigned IC_ARADDR_WIDTH    = 32;
  localparam int unsigned IC_RDATA_WIDTH     = 34;  // {r_data[31:0], r_resp[1:0]}
  localparam int unsigned IC_NUM_SLAVE_SLOTS = 4;

  // Slave 3 covers the whole 0x1xxx_xxxx window and overlaps slave 1.
  localparam logic [IC_ARADDR_WIDTH-1:0] IC_SLV_BASE [IC_NUM_SLAVE_SLOTS] = '{
    32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000
  };
  localparam logic [IC_ARADDR_WIDTH-1:0] IC_SLV_MASK [IC_NUM_SLAVE_SLOTS] = '{
    32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000
  };

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } ic_rd_state_e;

endpackage

// File: rtl/liteic_master_node_read_if.sv
// Bus bundle between an upstream read master, the read node and the crossbar slaves.
interface liteic_master_node_read_if
  import liteic_pkg::*;
#(
  parameter int unsigned NUM_SLV = IC_NUM_SLAVE_SLOTS
);

  // Every channel: a transfer happens on a rising clk edge where valid and ready
  // are both 1; the source keeps payload stable while valid waits for ready.
  logic [IC_ARADDR_WIDTH-1:0] mst_ar_addr_i;
  logic [3:0]                 mst_ar_qos_i;
  logic                       mst_ar_valid_i;
  logic                       mst_ar_ready_o;
  logic [IC_RDATA_WIDTH-3:0]  mst_r_data_o;
  logic [1:0]                 mst_r_resp_o;
  logic                       mst_r_valid_o;
  logic                       mst_r_ready_i;
  logic [IC_ARADDR_WIDTH-1:0] cbar_reqst_data_o;
  logic [3:0]                 cbar_reqst_arqos_o;
  logic [NUM_SLV-1:0]         cbar_reqst_val_o;
  logic [NUM_SLV-1:0]         cbar_reqst_rdy_i;
  logic [NUM_SLV-1:0]         cbar_resp_val_i;
  logic [NUM_SLV-1:0]         cbar_resp_rdy_o;
  logic [IC_RDATA_WIDTH-1:0]  cbar_resp_data_i [NUM_SLV];

  // slave: the read node itself; master: the upstream master plus crossbar side.
  modport slave (
    input  mst_ar_addr_i, mst_ar_qos_i, mst_ar_valid_i, mst_r_ready_i,
           cbar_reqst_rdy_i, cbar_resp_val_i, cbar_resp_data_i,
    output mst_ar_ready_o, mst_r_data_o, mst_r_resp_o, mst_r_valid_o,
           cbar_reqst_data_o, cbar_reqst_arqos_o, cbar_reqst_val_o, cbar_resp_rdy_o
  );

  modport master (
    output mst_ar_addr_i, mst_ar_qos_i, mst_ar_valid_i, mst_r_ready_i,
           cbar_reqst_rdy_i, cbar_resp_val_i, cbar_resp_data_i,
    input  mst_ar_ready_o, mst_r_data_o, mst_r_resp_o, mst_r_valid_o,
           cbar_reqst_data_o, cbar_reqst_arqos_o, cbar_reqst_val_o, cbar_resp_rdy_o
  );

endinterface

// File: rtl/liteic_master_node_read_decoder.sv
// Combinational address decoder: onehot slave select, lowest matching slot wins.
module liteic_addr_decoder
  import liteic_pkg::*;
#(
  parameter int unsigned NUM_SLV = IC_NUM_SLAVE_SLOTS
) (
  input  logic [IC_ARADDR_WIDTH-1:0] addr,
  output logic [NUM_SLV-1:0]         sel,
  output logic                       hit
);

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if (!hit && ((addr & IC_SLV_MASK[s]) == IC_SLV_BASE[s])) begin
        sel[s] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/liteic_master_node_read.sv
// Single-outstanding read node: decodes AR, forwards it to one crossbar slave, returns R.
// Optional request timeout is built when LITEIC_RD_TIMEOUT_EN is defined.
module liteic_master_node_read
  import liteic_pkg::*;
#(
  parameter int unsigned NUM_SLV        = IC_NUM_SLAVE_SLOTS,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  liteic_master_node_read_if.slave  bus,
  output ic_rd_state_e              dbg_state_o
);

  ic_rd_state_e               state_q;
  logic [IC_ARADDR_WIDTH-1:0] addr_q;
  logic [3:0]                 qos_q;
  logic [NUM_SLV-1:0]         sel_q;
  logic [NUM_SLV-1:0]         reqst_val_q;
  logic                       ar_ready_q;
  axi_resp_e                  err_resp_q;

  logic [NUM_SLV-1:0]         dec_sel;
  logic                       dec_hit;
  logic                       req_rdy;
  logic                       resp_val;
  logic [IC_RDATA_WIDTH-1:0]  resp_data;
  logic                       to_expired;

  liteic_addr_decoder #(.NUM_SLV(NUM_SLV)) u_dec (
    .addr (bus.mst_ar_addr_i),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // Only the selected slave's handshake bits are ever looked at.
  assign req_rdy  = |(bus.cbar_reqst_rdy_i & sel_q);
  assign resp_val = |(bus.cbar_resp_val_i & sel_q);

  always_comb begin
    resp_data = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if (sel_q[s]) resp_data = resp_data | bus.cbar_resp_data_i[s];
    end
  end

`ifdef LITEIC_RD_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q;

  assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_REQ) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign to_expired     = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      qos_q       <= '0;
      sel_q       <= '0;
      reqst_val_q <= '0;
      ar_ready_q  <= 1'b0;
      err_resp_q  <= OKAY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ar_ready_q <= 1'b1;
          if (ar_ready_q && bus.mst_ar_valid_i) begin
            ar_ready_q <= 1'b0;
            addr_q     <= bus.mst_ar_addr_i;
            qos_q      <= bus.mst_ar_qos_i;
            sel_q      <= dec_sel;
            if (dec_hit) begin
              state_q     <= ST_REQ;
              reqst_val_q <= dec_sel;
            end else begin
              state_q    <= ST_ERR;
              err_resp_q <= DECERR;
            end
          end
        end
        ST_REQ: begin
          if (req_rdy) begin
            state_q     <= ST_RESP;
            reqst_val_q <= '0;
          end else if (to_expired) begin
            state_q     <= ST_ERR;
            reqst_val_q <= '0;
            err_resp_q  <= SLVERR;
          end
        end
        ST_RESP: begin
          if (resp_val && bus.mst_r_ready_i) begin
            state_q    <= ST_IDLE;
            ar_ready_q <= 1'b1;
          end
        end
        ST_ERR: begin
          if (bus.mst_r_ready_i) begin
            state_q    <= ST_IDLE;
            ar_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mst_ar_ready_o     = ar_ready_q;
  assign bus.cbar_reqst_val_o   = reqst_val_q;
  assign bus.cbar_reqst_data_o  = (state_q == ST_REQ) ? addr_q : '0;
  assign bus.cbar_reqst_arqos_o = (state_q == ST_REQ) ? qos_q : '0;
  assign dbg_state_o            = state_q;

  // The R channel is a straight mux of the selected slave while in RESP.
  always_comb begin
    bus.mst_r_valid_o   = 1'b0;
    bus.mst_r_data_o    = '0;
    bus.mst_r_resp_o    = '0;
    bus.cbar_resp_rdy_o = '0;
    case (state_q)
      ST_RESP: begin
        bus.mst_r_valid_o                    = resp_val;
        {bus.mst_r_data_o, bus.mst_r_resp_o} = resp_data;
        bus.cbar_resp_rdy_o                  = bus.mst_r_ready_i ? sel_q : '0;
      end
      ST_ERR: begin
        bus.mst_r_valid_o = 1'b1;
        bus.mst_r_resp_o  = err_resp_q;
      end
      default: ;
    endcase
  end

endmodule
